cpu_cfg_slave: RTL and testbench

- CPU bus slave inside the switch DUT. Consumes the Peripheral side of the CPU interface (BusMode, Sel, Rd_DS, Wr_RW, Addr, DataIn, DataOut, Rdy_Dtack).
- Owns the 4096-entry VPI lookup table of CellCfgType entries (FWD port mask + VPI).
- Gives the cell-forwarding logic a 1-cycle-latency lookup read port. The CPU writes and reads the table through a 4-phase strobe/acknowledge handshake in Intel or Motorola bus mode.

---
 rtl/cpu_cfg_slave_pkg.sv | 26 ++
 rtl/cpu_cfg_slave_if.sv | 29 ++
 rtl/cpu_cfg_slave_lut.sv | 83 ++++++++
 rtl/cpu_cfg_slave.sv | 132 +++++++++++++
 tb/tb_cpu_cfg_slave.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_cfg_slave_pkg.sv
// Shared types for the CPU configuration slave: cell config entry, widths and FSM state codes.
// Optional parity support is controlled by CPU_CFG_PARITY_EN in the consuming modules.
package cpu_cfg_slave_pkg;

    localparam int unsigned NUM_TX = 4;
    localparam int unsigned FWD_W  = NUM_TX;
    localparam int unsigned VPI_W  = 12;

    typedef struct packed {
        logic [FWD_W-1:0] FWD;
        logic [VPI_W-1:0] VPI;
    } CellCfgType;

    localparam int unsigned CFG_W = $bits(CellCfgType);

    typedef logic [1:0] CpuSlvState_e;
    localparam CpuSlvState_e IDLE = 2'd0;
    localparam CpuSlvState_e WAIT = 2'd1;
    localparam CpuSlvState_e ACK  = 2'd2;

    // Parity bit that makes the entry plus parity contain an even number of ones.
    function automatic logic even_par(input CellCfgType d);
        return ^d;
    endfunction

endpackage

// File: rtl/cpu_cfg_slave_if.sv
// CPU bus interface: Sel, Rd_DS, Wr_RW and Rdy_Dtack are active-low; BusMode=1 is Intel, 0 is Motorola.
interface cpu_ifc;
    import cpu_cfg_slave_pkg::*;

    logic             BusMode;
    logic             Sel;
    logic             Rd_DS;
    logic             Wr_RW;
    logic [VPI_W-1:0] Addr;
    CellCfgType       DataIn;
    CellCfgType       DataOut;
    logic             Rdy_Dtack;

    modport master (
        output BusMode, Sel, Rd_DS, Wr_RW, Addr, DataIn,
        input  DataOut, Rdy_Dtack
    );

    modport slave (
        input  BusMode, Sel, Rd_DS, Wr_RW, Addr, DataIn,
        output DataOut, Rdy_Dtack
    );

    modport Peripheral (
        input  BusMode, Sel, Rd_DS, Wr_RW, Addr, DataIn,
        output DataOut, Rdy_Dtack
    );

endinterface

// File: rtl/cpu_cfg_slave_lut.sv
// VPI lookup table: one CPU write port, async CPU read port, registered lookup port.
// With CPU_CFG_PARITY_EN defined each entry also stores an even-parity bit checked on lookup.
module cpu_cfg_lut
    import cpu_cfg_slave_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [VPI_W-1:0] wr_addr,
    input  CellCfgType       wr_data,
`ifdef CPU_CFG_PARITY_EN
    input  logic             wr_par_inv,
    output logic             lkup_perr,
`endif
    input  logic [VPI_W-1:0] rd_addr,
    output CellCfgType       rd_data,
    input  logic             lkup_valid,
    input  logic [VPI_W-1:0] lkup_vpi,
    output CellCfgType       lkup_cfg,
    output logic             lkup_ack
);

    localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    CellCfgType       tbl [NUM_ENTRIES];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] lk_idx;

    assign wr_idx = wr_addr[IDX_W-1:0];
    assign rd_idx = rd_addr[IDX_W-1:0];
    assign lk_idx = lkup_vpi[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                tbl[i] <= '0;
            end
        end else if (wr_en) begin
            tbl[wr_idx] <= wr_data;
        end
    end

    assign rd_data = tbl[rd_idx];

    // Lookup samples the table before this edge's write lands, giving read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            lkup_cfg <= '0;
            lkup_ack <= 1'b0;
        end else begin
            lkup_ack <= lkup_valid;
            if (lkup_valid) begin
                lkup_cfg <= tbl[lk_idx];
            end
        end
    end

`ifdef CPU_CFG_PARITY_EN
    logic par_tbl [NUM_ENTRIES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                par_tbl[i] <= 1'b0;
            end
        end else if (wr_en) begin
            par_tbl[wr_idx] <= even_par(wr_data) ^ wr_par_inv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lkup_perr <= 1'b0;
        end else begin
            lkup_perr <= lkup_valid && (par_tbl[lk_idx] != even_par(tbl[lk_idx]));
        end
    end
`endif

endmodule

// File: rtl/cpu_cfg_slave.sv
// CPU bus slave owning the VPI config table; strobe/acknowledge FSM with WAIT_STATES delay.
// Define CPU_CFG_PARITY_EN to add per-entry parity with par_inject / lkup_perr ports.
module cpu_cfg_slave
    import cpu_cfg_slave_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned NUM_ENTRIES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    cpu_ifc.Peripheral       cpu,
`ifdef CPU_CFG_PARITY_EN
    input  logic             par_inject,
    output logic             lkup_perr,
`endif
    input  logic             lkup_valid,
    input  logic [VPI_W-1:0] lkup_vpi,
    output CellCfgType       lkup_cfg,
    output logic             lkup_ack
);

    CpuSlvState_e     state;
    logic [3:0]       cnt;
    logic [VPI_W-1:0] cap_addr;
    CellCfgType       cap_data;
    logic             cap_wr;
    logic             cap_mode;
    logic             rdy;
    CellCfgType       dout;

    logic             rd_req;
    logic             wr_req;
    logic             strobe_held;
    logic             commit;
    CellCfgType       rd_data;

    always_comb begin
        rd_req = 1'b0;
        wr_req = 1'b0;
        if (!cpu.Sel) begin
            if (cpu.BusMode) begin
                rd_req = !cpu.Rd_DS && cpu.Wr_RW;
                wr_req = cpu.Rd_DS && !cpu.Wr_RW;
            end else begin
                rd_req = !cpu.Rd_DS && cpu.Wr_RW;
                wr_req = !cpu.Rd_DS && !cpu.Wr_RW;
            end
        end
    end

    // The strobe that keeps a captured access alive is Wr_RW only for an Intel write; otherwise Rd_DS.
    always_comb begin
        strobe_held = !cpu.Sel && ((cap_mode && cap_wr) ? !cpu.Wr_RW : !cpu.Rd_DS);
    end

    assign commit = (state == ACK) && rdy && strobe_held;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_addr <= '0;
            cap_data <= '0;
            cap_wr   <= 1'b0;
            cap_mode <= 1'b0;
            rdy      <= 1'b1;
            dout     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req || wr_req) begin
                        cap_addr <= cpu.Addr;
                        cap_data <= cpu.DataIn;
                        cap_wr   <= wr_req;
                        cap_mode <= cpu.BusMode;
                        cnt      <= 4'(WAIT_STATES);
                        state    <= (WAIT_STATES == 0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (!strobe_held) begin
                        state <= IDLE;
                    end else if (cnt <= 4'd1) begin
                        state <= ACK;
                    end
                end
                ACK: begin
                    // First ACK cycle commits the access and drops Rdy_Dtack; later cycles wait for release.
                    if (rdy) begin
                        if (strobe_held) begin
                            rdy <= 1'b0;
                            if (!cap_wr) begin
                                dout <= rd_data;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!strobe_held) begin
                        rdy   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cpu.Rdy_Dtack = rdy;
    assign cpu.DataOut   = dout;

    cpu_cfg_lut #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_lut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (commit && cap_wr),
        .wr_addr    (cap_addr),
        .wr_data    (cap_data),
`ifdef CPU_CFG_PARITY_EN
        .wr_par_inv (par_inject),
        .lkup_perr  (lkup_perr),
`endif
        .rd_addr    (cap_addr),
        .rd_data    (rd_data),
        .lkup_valid (lkup_valid),
        .lkup_vpi   (lkup_vpi),
        .lkup_cfg   (lkup_cfg),
        .lkup_ack   (lkup_ack)
    );

endmodule

// File: tb/tb_cpu_cfg_slave.sv
// Directed bench for cpu_cfg_slave: scoreboard queues for CPU reads and lookups, immediate-assertion checks.
module tb_cpu_cfg_slave;
    import cpu_cfg_slave_pkg::*;

    localparam int unsigned WS  = 2;
    localparam int unsigned TMO = 40;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             lkup_valid;
    logic [VPI_W-1:0] lkup_vpi;
    CellCfgType       lkup_cfg;
    logic             lkup_ack;
`ifdef CPU_CFG_PARITY_EN
    logic             par_inject;
    logic             lkup_perr;
`endif

    cpu_ifc cpu_bus ();

    cpu_cfg_slave #(
        .WAIT_STATES(WS),
        .NUM_ENTRIES(4096)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu        (cpu_bus),
`ifdef CPU_CFG_PARITY_EN
        .par_inject (par_inject),
        .lkup_perr  (lkup_perr),
`endif
        .lkup_valid (lkup_valid),
        .lkup_vpi   (lkup_vpi),
        .lkup_cfg   (lkup_cfg),
        .lkup_ack   (lkup_ack)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    CellCfgType mdl [4096];
    CellCfgType exp_q [$];
    CellCfgType lk_q [$];
    CellCfgType last_rd;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4096; i++) mdl[i] = '0;
        last_rd = '0;
    endtask

    task automatic bus_idle();
        cpu_bus.Sel   = 1'b1;
        cpu_bus.Rd_DS = 1'b1;
        cpu_bus.Wr_RW = 1'b1;
    endtask

    function automatic CellCfgType pop_exp();
        if (exp_q.size() != 0) return exp_q.pop_front();
        return 'x;
    endfunction

    function automatic CellCfgType pop_lk();
        if (lk_q.size() != 0) return lk_q.pop_front();
        return 'x;
    endfunction

    task automatic start_access(input logic mode, input logic wr, input logic [11:0] addr,
                                input CellCfgType data);
        cpu_bus.BusMode = mode;
        cpu_bus.Addr    = addr;
        cpu_bus.DataIn  = data;
        cpu_bus.Sel     = 1'b0;
        if (mode) begin
            cpu_bus.Rd_DS = wr;
            cpu_bus.Wr_RW = !wr;
        end else begin
            cpu_bus.Rd_DS = 1'b0;
            cpu_bus.Wr_RW = !wr;
        end
        if (!wr) exp_q.push_back(mdl[addr]);
    endtask

    // Counts edges from driving the strobe: capture edge is 1, Rdy_Dtack falls WS+1 edges after it.
    task automatic wait_ack(input string tag, input logic [11:0] addr, input CellCfgType data);
        int unsigned lat = 0;
        do begin
            tick();
            lat++;
            if (lat == 1) begin
                cpu_bus.Addr   = ~addr;
                cpu_bus.DataIn = ~data;
            end
        end while (cpu_bus.Rdy_Dtack !== 1'b0 && lat < TMO);
        check({tag, "_lat"}, 32'(lat), 32'(WS + 2));
    endtask

    task automatic finish_access(input string tag, input logic mode, input logic wr);
        int unsigned low_cnt = 0;
        repeat (2) begin
            tick();
            if (cpu_bus.Rdy_Dtack === 1'b0) low_cnt++;
        end
        check({tag, "_hold"}, 32'(low_cnt), 32'd2);
        if (mode && wr) cpu_bus.Wr_RW = 1'b1;
        else            cpu_bus.Rd_DS = 1'b1;
        tick();
        check({tag, "_release"}, 32'(cpu_bus.Rdy_Dtack), 32'd1);
        bus_idle();
        tick();
    endtask

    task automatic cpu_xfer(input string tag, input logic mode, input logic wr,
                            input logic [11:0] addr, input CellCfgType data);
        CellCfgType e;
        start_access(mode, wr, addr, data);
        wait_ack(tag, addr, data);
        if (wr) begin
            mdl[addr] = data;
            check({tag, "_dout_held"}, 32'(cpu_bus.DataOut), 32'(last_rd));
        end else begin
            e = pop_exp();
            check({tag, "_data"}, 32'(cpu_bus.DataOut), 32'(e));
            last_rd = e;
        end
        finish_access(tag, mode, wr);
    endtask

    task automatic lookup(input string tag, input logic [11:0] addr);
        CellCfgType e;
        lkup_valid = 1'b1;
        lkup_vpi   = addr;
        lk_q.push_back(mdl[addr]);
        tick();
        e = pop_lk();
        check({tag, "_ack"}, 32'(lkup_ack), 32'd1);
        check({tag, "_cfg"}, 32'(lkup_cfg), 32'(e));
        lkup_valid = 1'b0;
        tick();
        check({tag, "_ack_idle"}, 32'(lkup_ack), 32'd0);
        check({tag, "_cfg_hold"}, 32'(lkup_cfg), 32'(e));
    endtask

    initial begin
        CellCfgType  e;
        int unsigned bad;

        clear_model();
        bus_idle();
        cpu_bus.BusMode = 1'b1;
        cpu_bus.Addr    = '0;
        cpu_bus.DataIn  = '0;
        lkup_valid      = 1'b0;
        lkup_vpi        = '0;
`ifdef CPU_CFG_PARITY_EN
        par_inject      = 1'b0;
`endif

        repeat (2) tick();
        check("rst_rdy", 32'(cpu_bus.Rdy_Dtack), 32'd1);
        check("rst_dout", 32'(cpu_bus.DataOut), 32'd0);
        check("rst_lkcfg", 32'(lkup_cfg), 32'd0);
        check("rst_lkack", 32'(lkup_ack), 32'd0);
        rst = 1'b0;
        tick();

        lookup("lk_empty", 12'h005);

        cpu_xfer("intel_wr", 1'b1, 1'b1, 12'h005, {4'b1010, 12'h05A});
        cpu_xfer("intel_rd", 1'b1, 1'b0, 12'h005, '0);
        lookup("lk_005", 12'h005);

        cpu_xfer("moto_wr", 1'b0, 1'b1, 12'hFFF, {4'b0101, 12'hA5C});
        cpu_xfer("moto_rd", 1'b0, 1'b0, 12'hFFF, '0);
        lookup("lk_fff", 12'hFFF);

        // Intel Rd_DS and Wr_RW both low: no access is accepted.
        cpu_bus.BusMode = 1'b1;
        cpu_bus.Sel     = 1'b0;
        cpu_bus.Rd_DS   = 1'b0;
        cpu_bus.Wr_RW   = 1'b0;
        bad = 0;
        repeat (8) begin
            tick();
            if (cpu_bus.Rdy_Dtack !== 1'b1) bad++;
        end
        check("proto_err_noack", 32'(bad), 32'd0);
        bus_idle();
        tick();

        // Abort: strobe released while in WAIT.
        start_access(1'b0, 1'b1, 12'h010, {4'b1111, 12'h123});
        tick();
        bus_idle();
        bad = 0;
        repeat (6) begin
            tick();
            if (cpu_bus.Rdy_Dtack !== 1'b1) bad++;
        end
        check("abort_noack", 32'(bad), 32'd0);
        check("abort_dout", 32'(cpu_bus.DataOut), 32'(last_rd));
        cpu_xfer("abort_rd", 1'b1, 1'b0, 12'h010, '0);

        // Collision: lookup sampled on the commit edge returns the old entry.
        cpu_xfer("col_pre", 1'b1, 1'b1, 12'h020, {4'b0011, 12'h111});
        start_access(1'b1, 1'b1, 12'h020, {4'b1100, 12'h222});
        repeat (WS + 1) tick();
        lkup_valid = 1'b1;
        lkup_vpi   = 12'h020;
        lk_q.push_back(mdl[12'h020]);
        tick();
        check("col_rdy", 32'(cpu_bus.Rdy_Dtack), 32'd0);
        e = pop_lk();
        check("col_ack", 32'(lkup_ack), 32'd1);
        check("col_old", 32'(lkup_cfg), 32'(e));
        mdl[12'h020] = {4'b1100, 12'h222};
        lk_q.push_back(mdl[12'h020]);
        tick();
        e = pop_lk();
        check("col_new", 32'(lkup_cfg), 32'(e));
        lkup_valid = 1'b0;
        finish_access("col_wr", 1'b1, 1'b1);

`ifdef CPU_CFG_PARITY_EN
        par_inject = 1'b1;
        cpu_xfer("par_bad_wr", 1'b1, 1'b1, 12'h040, {4'b1001, 12'h0F1});
        par_inject = 1'b0;
        lkup_valid = 1'b1;
        lkup_vpi   = 12'h040;
        tick();
        lkup_valid = 1'b0;
        check("par_bad_ack", 32'(lkup_ack), 32'd1);
        check("par_bad_perr", 32'(lkup_perr), 32'd1);
        cpu_xfer("par_bad_rd", 1'b1, 1'b0, 12'h040, '0);
        cpu_xfer("par_ok_wr", 1'b1, 1'b1, 12'h041, {4'b0110, 12'h3C7});
        lkup_valid = 1'b1;
        lkup_vpi   = 12'h041;
        tick();
        lkup_valid = 1'b0;
        check("par_ok_ack", 32'(lkup_ack), 32'd1);
        check("par_ok_perr", 32'(lkup_perr), 32'd0);
        tick();
`endif

        // Reset while a write to 0x030 sits in WAIT.
        start_access(1'b1, 1'b1, 12'h030, {4'b0111, 12'h333});
        repeat (2) tick();
        rst = 1'b1;
        bus_idle();
        tick();
        check("rstw_rdy", 32'(cpu_bus.Rdy_Dtack), 32'd1);
        check("rstw_lkack", 32'(lkup_ack), 32'd0);
        rst = 1'b0;
        clear_model();
        tick();
        cpu_xfer("rstw_rd030", 1'b1, 1'b0, 12'h030, '0);
        cpu_xfer("rstw_rd005", 1'b0, 1'b0, 12'h005, '0);
        lookup("rstw_lkfff", 12'hFFF);

        // Reset while Rdy_Dtack is low on a read.
        cpu_xfer("rsta_wr", 1'b1, 1'b1, 12'h7A5, {4'b1110, 12'hBEE});
        start_access(1'b1, 1'b0, 12'h7A5, '0);
        wait_ack("rsta_rd", 12'h7A5, '0);
        e = pop_exp();
        check("rsta_data", 32'(cpu_bus.DataOut), 32'(e));
        rst = 1'b1;
        bus_idle();
        tick();
        check("rsta_rdy", 32'(cpu_bus.Rdy_Dtack), 32'd1);
        check("rsta_dout", 32'(cpu_bus.DataOut), 32'd0);
        rst = 1'b0;
        clear_model();
        tick();
        cpu_xfer("rsta_rd_after", 1'b1, 1'b0, 12'h7A5, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
